// File: rtl/bufz_bus_pkg.sv
// Shared types and sizing helpers for the round-robin tri-state bus driver.
package bufz_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int DEAD_W = 4;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bufz_bus_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, cyclically.
module bufz_bus_rr_arb
  import bufz_bus_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int PTR_W = cnt_w(NCH - 1)
) (
  input  logic [NCH-1:0]   req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NCH-1:0]   gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = PTR_W'((int'(ptr_i) + k) % NCH);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/bufz_bus_driver.sv
// Round-robin owner of a shared tri-state bus with registered enables,
// break-before-make dead time and an optional hold limit.
module bufz_bus_driver
  import bufz_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int DEAD     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       req_i,
  input  logic [NCH*WIDTH-1:0] i_i,
  output logic [NCH-1:0]       gnt_o,
  output logic [NCH-1:0]       oe_o,
  output logic                 busy_o,
  output tri   [WIDTH-1:0]     z_o
);

  if (DEAD < 1 || DEAD > 15) begin : g_bad_dead
    $error("bufz_bus_driver: DEAD must be in 1..15");
  end
  if (NCH < 2 || NCH > 16) begin : g_bad_nch
    $error("bufz_bus_driver: NCH must be in 2..16");
  end

  localparam int PTR_W  = cnt_w(NCH - 1);
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [NCH-1:0]      gnt_q, gnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;

  logic [NCH-1:0]      arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                do_arb;
  logic                others_req;
  logic                hold_hit;
  logic [PTR_W-1:0]    next_ptr;
  logic [WIDTH-1:0]    bus_data;

  bufz_bus_rr_arb #(
    .NCH   (NCH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Preemption only counts once the owner has used its full allowance.
  assign others_req = |(req_i & ~gnt_q);
  assign hold_hit   = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);
  assign next_ptr   = (owner_q == PTR_W'(NCH - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    do_arb  = 1'b0;

    case (state_q)
      IDLE: do_arb = 1'b1;
      DRIVE: begin
        if (!req_i[owner_q] || (hold_hit && others_req)) begin
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = next_ptr;
          dead_d  = DEAD_INIT;
          hold_d  = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        if (dead_q <= DEAD_W'(1)) begin
          do_arb = 1'b1;
          dead_d = '0;
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_arb) begin
      if (arb_valid) begin
        state_d = DRIVE;
        gnt_d   = arb_gnt;
        owner_d = arb_idx;
        hold_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
    end
  end

  // AND-OR mux keyed on the one-hot grant: yields zeros, never X, when nobody owns the bus.
  always_comb begin
    bus_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_q[k]) bus_data |= i_i[k*WIDTH +: WIDTH];
    end
  end

  assign gnt_o  = gnt_q;
  assign oe_o   = gnt_q;
  assign busy_o = (state_q != IDLE);
  assign z_o    = (|gnt_q) ? bus_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bufz_bus_driver.sv
// Scoreboard bench: three driver instances (plain, long dead time, hold limit)
// share stimulus; a per-instance behavioural model predicts every cycle.
module tb_bufz_bus_driver;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NM = 3;

  typedef struct packed {
    logic [N-1:0] oe;
    logic         busy;
    logic [W-1:0] zval;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '1;
  logic [N*W-1:0] din = '0;

  wire  [N-1:0]   gnt_w [NM];
  wire  [N-1:0]   oe_w  [NM];
  wire            busy_w[NM];
  tri   [W-1:0]   z0, z1, z2;
  logic [W-1:0]   zv    [NM];

  assign zv[0] = z0;
  assign zv[1] = z1;
  assign zv[2] = z2;

  always #5 clk = ~clk;

  bufz_bus_driver #(.WIDTH(W), .NCH(N), .DEAD(1), .MAX_HOLD(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .i_i(din),
    .gnt_o(gnt_w[0]), .oe_o(oe_w[0]), .busy_o(busy_w[0]), .z_o(z0));
  bufz_bus_driver #(.WIDTH(W), .NCH(N), .DEAD(3), .MAX_HOLD(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .i_i(din),
    .gnt_o(gnt_w[1]), .oe_o(oe_w[1]), .busy_o(busy_w[1]), .z_o(z1));
  bufz_bus_driver #(.WIDTH(W), .NCH(N), .DEAD(1), .MAX_HOLD(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req), .i_i(din),
    .gnt_o(gnt_w[2]), .oe_o(oe_w[2]), .busy_o(busy_w[2]), .z_o(z2));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int dead_of(input int m);
    return (m == 1) ? 3 : 1;
  endfunction

  function automatic int hold_of(input int m);
    return (m == 2) ? 4 : 0;
  endfunction

  // ---------------- reference model: owner index, rotation pointer, cycles driven, Hi-Z cycles left
  int m_owner[NM];
  int m_ptr  [NM];
  int m_dc   [NM];
  int m_dead [NM];

  function automatic bit has_req(input logic [N-1:0] rq, input int c);
    return ((rq >> c) & 1) != 0;
  endfunction

  function automatic int pick(input int p, input logic [N-1:0] rq);
    for (int k = 0; k < N; k++) begin
      int c = (p + k) % N;
      if (has_req(rq, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d,
                            output exp_t [NM-1:0] ex);
    for (int m = 0; m < NM; m++) begin
      if (r) begin
        m_owner[m] = -1; m_ptr[m] = 0; m_dc[m] = 0; m_dead[m] = 0;
      end else if (m_owner[m] >= 0) begin
        bit others = (rq & ~(N'(1) << m_owner[m])) != 0;
        if (!has_req(rq, m_owner[m]) ||
            (hold_of(m) > 0 && m_dc[m] + 1 >= hold_of(m) && others)) begin
          m_ptr[m]   = (m_owner[m] + 1) % N;
          m_owner[m] = -1;
          m_dead[m]  = dead_of(m);
        end else begin
          m_dc[m]++;
        end
      end else if (m_dead[m] > 1) begin
        m_dead[m]--;
      end else begin
        m_dead[m]  = 0;
        m_owner[m] = pick(m_ptr[m], rq);
        m_dc[m]    = 0;
      end
      ex[m].oe   = (m_owner[m] >= 0) ? (N'(1) << m_owner[m]) : '0;
      ex[m].busy = (m_owner[m] >= 0) || (m_dead[m] > 0);
      ex[m].zval = (m_owner[m] >= 0) ? W'(d >> (m_owner[m] * W)) : '0;
    end
  endtask

  exp_t [NM-1:0] sbq[$];

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
    exp_t [NM-1:0] ex;
    @(negedge clk);
    rst = r;
    req = rq;
    din = d;
    model_step(r, rq, d, ex);
    sbq.push_back(ex);
  endtask

  // ---------------- monitor: compares every DUT cycle and tracks bus hand-over gaps
  logic [N-1:0] prev_oe  [NM];
  int           zero_run [NM];
  bit           had_owner[NM];
  int           last_gap [NM];
  bit           rec_en = 1'b0;
  int           order_q[$];

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (((v >> k) & 1) != 0) return k;
    return -1;
  endfunction

  initial begin
    for (int m = 0; m < NM; m++) begin
      prev_oe[m] = '0; zero_run[m] = 0; had_owner[m] = 1'b0; last_gap[m] = -1;
    end
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        exp_t [NM-1:0] ex;
        ex = sbq.pop_front();
        for (int m = 0; m < NM; m++) begin
          check($sformatf("oe[%0d]", m), 32'(oe_w[m]), 32'(ex[m].oe));
          check($sformatf("gnt[%0d]", m), 32'(gnt_w[m]), 32'(ex[m].oe));
          check($sformatf("busy[%0d]", m), 32'(busy_w[m]), 32'(ex[m].busy));
          check($sformatf("onehot0[%0d]", m), 32'($onehot0(oe_w[m])), 32'd1);
          if (ex[m].oe != '0) check($sformatf("z[%0d]", m), 32'(zv[m]), 32'(ex[m].zval));
          if (rst) begin
            zero_run[m] = 0; had_owner[m] = 1'b0;
          end else if (oe_w[m] == '0) begin
            zero_run[m]++;
          end else if (prev_oe[m] == '0) begin
            if (had_owner[m]) begin
              check($sformatf("dead_min[%0d]", m), 32'(zero_run[m] >= dead_of(m)), 32'd1);
              last_gap[m] = zero_run[m];
            end
            zero_run[m]  = 0;
            had_owner[m] = 1'b1;
            if (m == 0 && rec_en) order_q.push_back(onehot_idx(oe_w[m]));
          end else begin
            check($sformatf("oe_stable[%0d]", m), 32'(oe_w[m]), 32'(prev_oe[m]));
          end
          prev_oe[m] = oe_w[m];
        end
      end
    end
  end

  // ---------------- stimulus
  logic [N-1:0]   one = 1;
  logic [N-1:0]   rnd_req;
  logic [N*W-1:0] d_a5;
  int             exp_order[5] = '{0, 1, 2, 3, 0};
  int             guard;

  initial begin
    for (int m = 0; m < NM; m++) begin
      m_owner[m] = -1; m_ptr[m] = 0; m_dc[m] = 0; m_dead[m] = 0;
    end

    // Reset held two clocks with every channel requesting.
    step(1'b1, 4'b1111, $urandom);
    step(1'b1, 4'b1111, $urandom);

    // Single requester on channel 2 carrying 8'hA5, then release.
    d_a5 = $urandom;
    d_a5[2*W +: W] = 8'hA5;
    repeat (4) step(1'b0, 4'b0100, d_a5);
    repeat (5) step(1'b0, 4'b0000, $urandom);

    // Rotation: all request, owner drops after three drive cycles.
    step(1'b1, 4'b0000, $urandom);
    rec_en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      guard = 0;
      while (m_owner[0] < 0 && guard < 20) begin
        step(1'b0, 4'b1111, $urandom);
        guard++;
      end
      if (m_owner[0] >= 0) begin
        step(1'b0, 4'b1111, $urandom);
        step(1'b0, 4'b1111, $urandom);
        step(1'b0, ~(one << m_owner[0]), $urandom);
      end
    end
    rec_en = 1'b0;
    repeat (4) step(1'b0, 4'b0000, $urandom);
    check("rot_count", 32'(order_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < order_q.size()) check($sformatf("rot_order[%0d]", k), 32'(order_q[k]), 32'(exp_order[k]));
      else check($sformatf("rot_order[%0d]", k), 32'hFFFF_FFFF, 32'(exp_order[k]));
    end

    // Dead time: owner 1 releases while channel 3 waits.
    step(1'b1, 4'b0000, $urandom);
    last_gap[1] = -1;
    repeat (3) step(1'b0, 4'b0010, $urandom);
    repeat (2) step(1'b0, 4'b1010, $urandom);
    repeat (7) step(1'b0, 4'b1000, $urandom);
    repeat (5) step(1'b0, 4'b0000, $urandom);
    check("dead3_gap", 32'(last_gap[1]), 32'd3);

    // Hold limit: channel 0 held, channel 2 arrives two cycles later.
    step(1'b1, 4'b0000, $urandom);
    repeat (2) step(1'b0, 4'b0001, $urandom);
    repeat (14) step(1'b0, 4'b0101, $urandom);
    repeat (6) step(1'b0, 4'b0000, $urandom);

    // Reset while channel 1 drives with a non-zero pointer; grant afterwards starts from 0.
    step(1'b1, 4'b0000, $urandom);
    repeat (2) step(1'b0, 4'b0010, $urandom);
    repeat (4) step(1'b0, 4'b0000, $urandom);
    repeat (3) step(1'b0, 4'b0010, $urandom);
    step(1'b1, 4'b0010, $urandom);
    repeat (4) step(1'b0, 4'b1111, $urandom);
    repeat (5) step(1'b0, 4'b0000, $urandom);

    // Random traffic with sticky requests and rare resets.
    rnd_req = '0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 3) == 0) rnd_req[k] = ~rnd_req[k];
      step(($urandom_range(0, 99) == 0), rnd_req, $urandom);
    end
    repeat (3) step(1'b0, 4'b0000, $urandom);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
